// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed 8-digit seven-segment scan controller.
// Each digit owns a slot of TICK_DIV clocks. The first BLANK_CYC clocks of
// every slot are a guard phase with all digits dark. After that, the digit's
// shadowed value is driven. All outputs are registered, so they lag the
// scan state by one clock.
// Optional feature macro: LEADING_ZERO_BLANK_EN (leading-zero suppression).
module seg_scan_ctrl #(
  parameter int TICK_DIV  = 100000,
  parameter int BLANK_CYC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [4:0] wr_data,
  output logic [6:0] inv_leds,
  output logic [7:0] enb_leds,
  output logic       frame_done
);

  localparam int             CW        = $clog2(TICK_DIV);
  localparam logic [CW-1:0]  CNT_LAST  = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0]  CNT_GUARD = CW'(BLANK_CYC);
  localparam logic [4:0]     ENTRY_BLANK = 5'b10000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GUARD = 2'd1,
    ST_DRIVE = 2'd2
  } state_t;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex digit.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] seg;
    case (v)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  logic [4:0]    digit_buf_r [8];
  logic [4:0]    shadow_r;
  logic [CW-1:0] div_cnt_r;
  logic [2:0]    slot_r;
  logic [6:0]    inv_leds_r;
  logic [7:0]    enb_leds_r;
  logic          frame_done_r;

  state_t        state_s;
  logic          wrap_s;
  logic          latch_s;
  logic          lz_blank_s;
  logic [6:0]    inv_nxt_s;
  logic [7:0]    enb_nxt_s;

  assign wrap_s  = en && (div_cnt_r == CNT_LAST);
  assign latch_s = en && (div_cnt_r == {CW{1'b0}});

`ifdef LEADING_ZERO_BLANK_EN
  logic [4:0] snap_r [8];
  logic [7:0] keep_s;
  logic       acc_s;

  // Snapshot of the whole buffer taken together with the shadow latch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) snap_r[i] <= ENTRY_BLANK;
    end else if (latch_s) begin
      for (int i = 0; i < 8; i++) snap_r[i] <= digit_buf_r[i];
    end else begin
      for (int i = 0; i < 8; i++) snap_r[i] <= snap_r[i];
    end
  end

  // A digit is kept if it or any higher digit holds a visible non-zero value.
  always_comb begin
    acc_s  = 1'b0;
    keep_s = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      acc_s     = acc_s | (~snap_r[i][4] & (snap_r[i][3:0] != 4'd0));
      keep_s[i] = acc_s;
    end
    keep_s[0] = 1'b1;
  end

  assign lz_blank_s = ~keep_s[slot_r];
`else
  assign lz_blank_s = 1'b0;
`endif

  // Digit buffer: direct write port, no backpressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) digit_buf_r[i] <= ENTRY_BLANK;
    end else if (wr_en) begin
      digit_buf_r[wr_addr] <= wr_data;
    end else begin
      for (int i = 0; i < 8; i++) digit_buf_r[i] <= digit_buf_r[i];
    end
  end

  // Scan state and next-output decode from the current counters.
  always_comb begin
    state_s   = ST_IDLE;
    enb_nxt_s = 8'hFF;
    inv_nxt_s = 7'h7F;
    if (!en) begin
      state_s = ST_IDLE;
    end else if (div_cnt_r < CNT_GUARD) begin
      state_s = ST_GUARD;
    end else begin
      state_s = ST_DRIVE;
    end
    case (state_s)
      ST_IDLE, ST_GUARD: begin
        enb_nxt_s = 8'hFF;
        inv_nxt_s = 7'h7F;
      end
      ST_DRIVE: begin
        if (shadow_r[4] || lz_blank_s) begin
          enb_nxt_s = 8'hFF;
          inv_nxt_s = 7'h7F;
        end else begin
          enb_nxt_s = ~(8'd1 << slot_r);
          inv_nxt_s = hex7(shadow_r[3:0]);
        end
      end
      default: begin
        enb_nxt_s = 8'hFF;
        inv_nxt_s = 7'h7F;
      end
    endcase
  end

  // Slot counters, shadow latch and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_r    <= {CW{1'b0}};
      slot_r       <= 3'd0;
      shadow_r     <= ENTRY_BLANK;
      enb_leds_r   <= 8'hFF;
      inv_leds_r   <= 7'h7F;
      frame_done_r <= 1'b0;
    end else begin
      enb_leds_r   <= enb_nxt_s;
      inv_leds_r   <= inv_nxt_s;
      frame_done_r <= wrap_s && (slot_r == 3'd7);
      if (latch_s) begin
        shadow_r <= digit_buf_r[slot_r];
      end else begin
        shadow_r <= shadow_r;
      end
      if (wrap_s) begin
        div_cnt_r <= {CW{1'b0}};
        slot_r    <= slot_r + 3'd1;
      end else if (en) begin
        div_cnt_r <= div_cnt_r + {{(CW-1){1'b0}}, 1'b1};
        slot_r    <= slot_r;
      end else begin
        div_cnt_r <= div_cnt_r;
        slot_r    <= slot_r;
      end
    end
  end

  assign inv_leds   = inv_leds_r;
  assign enb_leds   = enb_leds_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (TICK_DIV=8, BLANK_CYC=2).
// Reference model tracks the scan as one frame position 0..63 and derives
// slot/count by division; expected outputs come from that position.
module tb_seg_scan_ctrl;

  localparam int T  = 8;
  localparam int B  = 2;
  localparam int FR = 8 * T;

  localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = 3'd0;
  logic [4:0] wr_data = 5'd0;
  logic [6:0] inv_leds;
  logic [7:0] enb_leds;
  logic       frame_done;

  int n_cmp = 0;
  int n_bad = 0;
  int fd_seen = 0;

  int         m_pos;
  logic [4:0] m_buf [8];
  logic [4:0] m_snap [8];
  logic [4:0] m_shadow;
  logic [7:0] exp_enb;
  logic [6:0] exp_inv;
  logic       exp_fd;

  seg_scan_ctrl #(.TICK_DIV(T), .BLANK_CYC(B)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .inv_leds(inv_leds), .enb_leds(enb_leds), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic bit suppressed(input int sl);
`ifdef LEADING_ZERO_BLANK_EN
    int hi = -1;
    for (int i = 0; i < 8; i++)
      if (!m_snap[i][4] && m_snap[i][3:0] != 4'd0) hi = i;
    return (sl != 0) && (sl > hi);
`else
    return (sl < 0);
`endif
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    int cnt, sl;
    if (!rst_n) begin
      m_pos = 0;
      for (int i = 0; i < 8; i++) begin m_buf[i] = 5'h10; m_snap[i] = 5'h10; end
      m_shadow = 5'h10;
      exp_enb = 8'hFF; exp_inv = 7'h7F; exp_fd = 1'b0;
    end else begin
      cnt = m_pos % T;
      sl  = m_pos / T;
      exp_enb = 8'hFF; exp_inv = 7'h7F;
      if (en && cnt >= B && !m_shadow[4] && !suppressed(sl)) begin
        exp_enb = 8'hFF ^ (8'(1) << sl);
        exp_inv = SEG[m_shadow[3:0]];
      end
      exp_fd = en && (m_pos == FR - 1);
      if (en && cnt == 0) begin
        m_shadow = m_buf[sl];
        for (int i = 0; i < 8; i++) m_snap[i] = m_buf[i];
      end
      if (en) m_pos = (m_pos + 1) % FR;
      if (wr_en) m_buf[wr_addr] = wr_data;
    end
  endtask

  task automatic step(input logic r, input logic e, input logic w,
                      input logic [2:0] a, input logic [4:0] d);
    @(negedge clk);
    rst_n = r; en = e; wr_en = w; wr_addr = a; wr_data = d;
    @(posedge clk);
    model_step();
    #1;
    chk("enb_leds", {24'd0, enb_leds}, {24'd0, exp_enb});
    chk("inv_leds", {25'd0, inv_leds}, {25'd0, exp_inv});
    chk("frame_done", {31'd0, frame_done}, {31'd0, exp_fd});
    if (frame_done) fd_seen++;
  endtask

  initial begin
    int vals [8] = '{3, 1, 8, 15, 0, 2, 10, 12};
    int lz   [8] = '{0, 0, 5, 0, 0, 0, 0, 0};

    // Reset and the reset-state outputs.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 3'd4, 5'd7);
    chk("rst_enb", {24'd0, enb_leds}, 32'hFF);
    chk("rst_inv", {25'd0, inv_leds}, 32'h7F);

    // Load 3,1,8,F,0,2,A,C while idle.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, 3'(i), 5'(vals[i]));

    // Three frames; rewrite digit 2 to 9 mid-DRIVE of slot 2.
    fd_seen = 0;
    for (int k = 0; k < 3 * FR; k++) begin
      if (k == 2 * T + 4) step(1'b1, 1'b1, 1'b1, 3'd2, 5'd9);
      else step(1'b1, 1'b1, 1'b0, 3'd0, 5'd0);
      if (k == 2 * T + 6) chk("slot2_old", {25'd0, inv_leds}, 32'h00);
      if (k == FR + 2 * T + 6) chk("slot2_new", {25'd0, inv_leds}, 32'h10);
      if (k == 3 * T + 5) chk("slot3_F", {25'd0, inv_leds}, 32'h0E);
      if (k == 5) chk("slot0_3", {25'd0, inv_leds}, 32'h30);
    end
    chk("fd_count", 32'(fd_seen), 32'd3);

    // Pause mid-DRIVE of slot 5 for 20 clocks, resume, then reset in slot 6.
    fd_seen = 0;
    for (int k = 0; k < 5 * T + 4; k++) step(1'b1, 1'b1, 1'b0, 3'd0, 5'd0);
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b0, 1'b0, 3'd0, 5'd0);
      if (k > 0) chk("idle_enb", {24'd0, enb_leds}, 32'hFF);
    end
    for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 1'b0, 3'd0, 5'd0);
    step(1'b0, 1'b1, 1'b1, 3'd1, 5'd3);
    chk("pause_no_fd", 32'(fd_seen), 32'd0);
    for (int k = 0; k < 2 * FR; k++) step(1'b1, 1'b1, 1'b0, 3'd0, 5'd0);
    chk("blank_after_rst", {24'd0, enb_leds}, 32'hFF);

    // Randomized traffic with occasional reset and enable gaps.
    for (int k = 0; k < 3000; k++)
      step(($urandom % 300) != 0, ($urandom % 6) != 0, ($urandom % 3) == 0,
           3'($urandom % 8), 5'($urandom % 32));

    // Leading-zero pattern: digit 2 = 5, the rest 0.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, 3'(i), 5'(lz[i]));
    for (int k = 0; k < 3 * FR; k++) step(1'b1, 1'b1, 1'b0, 3'd0, 5'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
